// File: rtl/signed_frame_accumulator.sv
// Sums fixed-length frames of signed samples with saturating arithmetic and
// holds each frame total (plus sticky saturation flag) until the sink takes it.
module signed_frame_accumulator #(
    parameter int DATA_W = 4,
    parameter int SUM_W  = 6,
    parameter int COUNT  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic signed [SUM_W:0] MAX_V = {2'b00, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W:0] MIN_V = {2'b11, {(SUM_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [SUM_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               sat_reg, sat_next;
    logic [SUM_W-1:0]   out_sum_reg, out_sum_next;
    logic               out_sat_reg, out_sat_next;

    logic signed [SUM_W:0] in_ext, acc_ext, raw_sum;
    logic [SUM_W-1:0]      clamped;
    logic                  ovf;
    logic                  accept;

    // One guard bit above the accumulator width lets the raw add overflow
    // detectably before clamping.
    genvar gi;
    generate
        for (gi = 0; gi <= SUM_W; gi++) begin : g_ext
            if (gi < DATA_W) begin : g_in_lo
                assign in_ext[gi] = in_data[gi];
            end else begin : g_in_hi
                assign in_ext[gi] = in_data[DATA_W-1];
            end
            if (gi < SUM_W) begin : g_acc_lo
                assign acc_ext[gi] = acc_reg[gi];
            end else begin : g_acc_hi
                assign acc_ext[gi] = acc_reg[SUM_W-1];
            end
        end
    endgenerate

    assign raw_sum = in_ext + acc_ext;

    always_comb begin
        clamped = raw_sum[SUM_W-1:0];
        ovf     = 1'b0;
        if (raw_sum > MAX_V) begin
            clamped = MAX_V[SUM_W-1:0];
            ovf     = 1'b1;
        end else if (raw_sum < MIN_V) begin
            clamped = MIN_V[SUM_W-1:0];
            ovf     = 1'b1;
        end
    end

    assign in_ready  = rst_n && (state_reg != HOLD);
    assign out_valid = (state_reg == HOLD);
    assign out_sum   = out_sum_reg;
    assign out_sat   = out_sat_reg;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            sat_reg     <= 1'b0;
            out_sum_reg <= '0;
            out_sat_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            sat_reg     <= sat_next;
            out_sum_reg <= out_sum_next;
            out_sat_reg <= out_sat_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        sat_next     = sat_reg;
        out_sum_next = out_sum_reg;
        out_sat_next = out_sat_reg;
        if (clear) begin
            // Abort wins over accepts and over a pending result handshake.
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            sat_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_next = clamped;
                        sat_next = sat_reg | ovf;
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(COUNT - 1)) begin
                            state_next   = HOLD;
                            out_sum_next = clamped;
                            out_sat_next = sat_reg | ovf;
                        end else begin
                            state_next = ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                        sat_next   = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Scoreboard bench: stimulus pushes expected frame totals from a plain
// arithmetic reference; a monitor checks them whenever a result is presented.
`timescale 1ns/1ps
module tb_signed_frame_accumulator;
    localparam int DATA_W = 4;
    localparam int SUM_W  = 6;
    localparam int COUNT  = 8;
    localparam int MAXV   = 2**(SUM_W-1) - 1;
    localparam int MINV   = -(2**(SUM_W-1));

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SUM_W-1:0]  out_sum;
    logic              out_sat;
    logic              out_valid;
    logic              out_ready = 1'b1;

    signed_frame_accumulator #(.DATA_W(DATA_W), .SUM_W(SUM_W), .COUNT(COUNT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_sum(out_sum), .out_sat(out_sat), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { int sum; bit sat; } exp_t;
    exp_t exp_q[$];
    int   cur[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    bit   rand_or = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Reference: running signed total, clamped to the result range after every add.
    function automatic exp_t ref_frame(input int s[$]);
        exp_t e;
        e.sum = 0;
        e.sat = 1'b0;
        foreach (s[i]) begin
            e.sum = e.sum + s[i];
            if (e.sum > MAXV) begin e.sum = MAXV; e.sat = 1'b1; end
            else if (e.sum < MINV) begin e.sum = MINV; e.sat = 1'b1; end
        end
        return e;
    endfunction

    // Monitor: sampled 2 ns after the falling edge, away from both clock edges.
    int got_sum;
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            got_sum = int'($signed(out_sum));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0d sat %0d expected no result", got_sum, out_sat);
            end else begin
                chk("out_sum", got_sum, exp_q[0].sum);
                chk("out_sat", int'(out_sat), int'(exp_q[0].sat));
                if (clear) void'(exp_q.pop_front());
                else if (out_ready) begin
                    void'(exp_q.pop_front());
                    xfers++;
                end
            end
        end
    end

    task automatic send(input int x);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        @(negedge clk);
        in_data  = DATA_W'(x);
        in_valid = 1'b1;
        while (!in_ready && t < 60) begin
            if (rand_or) out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        cur.push_back(x);
        if (cur.size() == COUNT) begin
            exp_q.push_back(ref_frame(cur));
            cur.delete();
            done = 1'b1;
        end
        if (done) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("latency_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            if (out_ready) begin
                @(negedge clk);
                chk("post_xfer_in_ready", int'(in_ready), 1);
                chk("post_xfer_out_valid", int'(out_valid), 0);
            end
        end
    endtask

    task automatic send_list(input int s[$]);
        foreach (s[i]) send(s[i]);
    endtask

    initial begin
        int prev_sum;
        int prev_x;
        int s[$];

        // Reset state
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle_in_ready", int'(in_ready), 1);

        // Normal frame
        send_list('{-1, 7, -8, 3, 2, -2, 5, -4});
        // Positive saturation, then a zero frame clears sat
        send_list('{7, 7, 7, 7, 7, 7, 7, 7});
        send_list('{0, 0, 0, 0, 0, 0, 0, 0});
        // Negative saturation, then recovery
        send_list('{-8, -8, -8, -8, -8, -8, -8, -8});
        send_list('{7, 7, 7, 7, 0, 0, 0, 0});

        // Backpressure with the next sample held on the input
        out_ready = 1'b0;
        send_list('{3, -2, 5, 1, 6, -7, 4, 2});
        in_data  = DATA_W'(5);
        in_valid = 1'b1;
        prev_sum = int'(out_sum);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_sum_stable", int'(out_sum), prev_sum);
        end
        out_ready = 1'b1;
        send_list('{5, 5, -3, 2, 7, -1, 0, 4});

        // Asynchronous reset mid-frame
        send_list('{6, 6, 6});
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_sum", int'(out_sum), 0);
        chk("async_rst_out_sat", int'(out_sat), 0);
        chk("async_rst_in_ready", int'(in_ready), 0);
        cur.delete();
        exp_q.delete();
        #1 rst_n = 1'b1;
        send_list('{1, 2, 3, 4, -5, -6, 7, 1});

        // clear together with an offered sample after 5 accepts
        send_list('{7, 7, 7, 7, 7});
        @(negedge clk);
        in_data  = DATA_W'(-8);
        in_valid = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        cur.delete();
        #1 chk("clear_out_valid", int'(out_valid), 0);
        send_list('{2, -3, 4, -5, 6, -7, 1, 1});

        // clear during HOLD with out_ready high drops the result
        out_ready = 1'b0;
        send_list('{1, 1, 1, 1, 1, 1, 1, -3});
        prev_x = xfers;
        @(negedge clk);
        out_ready = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clear_hold_out_valid", int'(out_valid), 0);
        chk("clear_hold_no_xfer", xfers, prev_x);
        chk("clear_hold_queue", exp_q.size(), 0);

        // Randomized frames with input gaps and sink backpressure
        rand_or = 1'b1;
        for (int f = 0; f < 25; f++) begin
            s.delete();
            for (int i = 0; i < COUNT; i++) s.push_back(int'($urandom_range(0, 15)) - 8);
            foreach (s[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = DATA_W'($urandom_range(0, 15));
                end
                send(s[i]);
            end
        end
        rand_or = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/signed_frame_accumulator.md
Name: signed_frame_accumulator

Overview:
- Downstream consumer of the 4-bit binary-to-two's-complement converter.
- Accepts a stream of signed two's-complement samples over a valid/ready handshake.
- Sums a fixed-length frame of COUNT samples with saturating arithmetic and presents the frame total with a sticky saturation flag.
- Holds the result until the sink takes it, then starts the next frame.

Parameters:
- DATA_W, 4: width of signed input sample (matches converter output).
- SUM_W, 6: width of signed accumulator/result. Must be > DATA_W.
- COUNT, 8: samples per frame. Must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort, active high.
- in_data  input  DATA_W  signed two's-complement sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- out_sum  output  SUM_W  signed frame total (registered).
- out_sat  output  1  saturation occurred during this frame (registered).
- out_valid  output  1  out_sum/out_sat hold a completed frame.
- out_ready  input  1  sink accepts result.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, takes effect immediately, asynchronous):
  - state=IDLE; accumulator, sample counter and sat flag cleared.
  - out_sum=0, out_sat=0, out_valid=0.
  - in_ready=0 while rst_n is low.
- States:
  - IDLE: no samples taken yet. in_ready=1.
  - ACCUM: 1..COUNT-1 samples taken. in_ready=1.
  - HOLD: result presented. in_ready=0, out_valid=1.
- Input accept: on a rising edge with in_valid && in_ready. in_valid gaps are allowed; the counter advances only on accepts.
- Accumulation on each accept:
  - Sign-extend in_data and acc to SUM_W+1 bits and add.
  - If the result > 2^(SUM_W-1)-1, clamp to that maximum; if < -2^(SUM_W-1), clamp to that minimum; in either case set sat.
  - sat is sticky for the frame. acc may leave the clamp value on later adds.
- Transitions:
  - IDLE to ACCUM on an accept, when COUNT > 1.
  - Frame completion: the COUNT-th accept moves the block to HOLD and loads out_sum with the final acc and out_sat with the final sat, all on the same edge. out_valid is high the following cycle. With COUNT=1, the first accept goes from IDLE directly to HOLD.
  - Latency: out_valid rises 1 cycle after the final accept.
  - HOLD: out_sum and out_sat stay stable until out_valid && out_ready on an edge. On that edge the block returns to IDLE, clears acc, counter and sat, and deasserts out_valid. out_sum and out_sat keep their last value. in_ready is 1 the next cycle. No input is accepted in the handshake cycle.
- clear:
  - Synchronous; priority below reset, above everything else.
  - Goes to IDLE, clears acc, counter, sat and out_valid.
  - A sample offered in the same cycle is discarded.
  - A held result is dropped even if out_ready is high.
- in_ready is combinational from state and rst_n only; it never depends on in_valid.
- out_valid does not depend combinationally on out_ready.
- Counter width is clog2(COUNT+1). Counter wrap is impossible because the block leaves ACCUM at COUNT.

Test Plan:
1. Normal frame: defaults; samples -1, 7, -8, 3, 2, -2, 5, -4 (hex F, 7, 8, 3, 2, E, 5, C), in_valid back-to-back, out_ready=1 -> out_valid 1 cycle after the 8th accept; out_sum=2 (6'b000010), out_sat=0; in_ready=0 for exactly one cycle.
2. Positive saturation: eight samples of 7 -> out_sum=31 (6'b011111), out_sat=1. Next frame of eight 0s -> out_sum=0, out_sat=0 (sat flag cleared between frames).
3. Negative saturation and recovery: eight -8s -> out_sum=-32 (6'b100000), out_sat=1. Frame of four 7s then four 0s -> 28, sat=0.
4. Backpressure: hold out_ready=0 for 5 cycles after a frame completes, with in_valid held high -> in_ready=0 throughout; out_sum stable; no sample lost. After the handshake, the next 8 offered samples form the next frame exactly.
5. Mid-frame reset: pulse rst_n low asynchronously (between edges) after 3 accepts -> out_valid, out_sum and out_sat go to 0 immediately. The next full frame gives the correct fresh sum.
6. clear: assert clear in the same cycle as an accepted sample after 5 accepts -> that sample is discarded, counter=0. Assert clear during HOLD with out_ready=1 -> out_valid drops and no transfer occurs.
